// File: rtl/prng_pkg.sv
// Shared defaults and the single-step Galois LFSR function used by the PRNG source.
package prng_pkg;
  localparam int unsigned DEF_LFSR_WIDTH = 8;
  localparam int unsigned DEF_LFSR_SEED  = 1;
  localparam logic [31:0] DEF_LFSR_POLY  = 32'h0000_00B8;
  localparam int unsigned DEF_OUT_WIDTH  = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned STEP_W         = 32;

  typedef struct packed {
    logic              bit_out;
    logic [STEP_W-1:0] state;
  } step_t;

  // Widths up to 32 share one function: narrower states are zero-extended.
  function automatic step_t lfsr_step(input logic [STEP_W-1:0] state,
                                      input logic [STEP_W-1:0] poly);
    step_t r;
    r.bit_out = state[0];
    r.state   = (state >> 1) ^ (state[0] ? poly : '0);
    return r;
  endfunction
endpackage

// File: rtl/fifo.sv
// First-word-fall-through buffer with flush and occupancy level; status outputs are registered.
module fifo #(
  parameter int unsigned FIFO_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push,
  input  logic [FIFO_WIDTH-1:0]         din,
  input  logic                          pop,
  output logic [FIFO_WIDTH-1:0]         dout,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          full,
  output logic                          empty
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_next;
  logic                  do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    level_next = level;
    if (flush)
      level_next = '0;
    else if (do_push && !do_pop)
      level_next = level + LW'(1);
    else if (!do_push && do_pop)
      level_next = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      valid  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      level <= level_next;
      full  <= (level_next == LW'(FIFO_DEPTH));
      empty <= (level_next == '0);
      valid <= (level_next != '0);
    end
  end

  // Gated so the head reads zero whenever nothing is stored.
  assign dout = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/prng_fifo_source.sv
// Galois-LFSR word generator feeding a FWFT buffer, in continuous-fill or on-demand mode.
module prng_fifo_source
  import prng_pkg::*;
#(
  parameter int unsigned           LFSR_WIDTH = DEF_LFSR_WIDTH,
  parameter int unsigned           LFSR_SEED  = DEF_LFSR_SEED,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = LFSR_WIDTH'(DEF_LFSR_POLY),
  parameter int unsigned           OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned           FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        auto_fill,
  input  logic                        enable,
  input  logic                        req,
  input  logic                        seed_load,
  input  logic [LFSR_WIDTH-1:0]       seed_value,
  input  logic                        flush,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        full,
  output logic                        empty,
  output logic                        req_dropped,
  output logic [31:0]                 word_count
);
  localparam logic [LFSR_WIDTH-1:0] SEED_W = LFSR_WIDTH'(LFSR_SEED);

  logic [LFSR_WIDTH-1:0] state, state_next;
  logic [OUT_WIDTH-1:0]  word;
  logic                  gen, pop;

  // All OUT_WIDTH steps unrolled in one cycle; bit 0 is the first step.
  always_comb begin
    step_t             s;
    logic [STEP_W-1:0] cur;
    cur  = STEP_W'(state);
    word = '0;
    for (int i = 0; i < int'(OUT_WIDTH); i++) begin
      s       = lfsr_step(cur, STEP_W'(LFSR_POLY));
      word[i] = s.bit_out;
      cur     = s.state;
    end
    state_next = cur[LFSR_WIDTH-1:0];
  end

  assign gen = !full && !seed_load && !flush && (auto_fill ? enable : req);
  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEED_W;
      word_count  <= '0;
      req_dropped <= 1'b0;
    end else begin
      req_dropped <= req && full && !auto_fill;
      if (seed_load)
        state <= (seed_value == '0) ? SEED_W : seed_value;
      else if (gen) begin
        state      <= state_next;
        word_count <= word_count + 32'd1;
      end
    end
  end

  fifo #(
    .FIFO_WIDTH (OUT_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (gen),
    .din   (word),
    .pop   (pop),
    .dout  (out_data),
    .valid (out_valid),
    .level (level),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: doc/prng_fifo_source.md
PRNG_FIFO_SOURCE -- requirements
Module: prng_fifo_source

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter LFSR_WIDTH, default 8: LFSR state width, 4..32.
REQ-003 Parameter LFSR_SEED, default 1: reset seed, and the substitute for any zero seed.
REQ-004 Parameter LFSR_POLY, default 8'hB8: Galois feedback mask, LFSR_WIDTH bits.
REQ-005 Parameter OUT_WIDTH, default 4: bits generated per word, 1..LFSR_WIDTH.
REQ-006 Parameter FIFO_DEPTH, default 16: buffer depth, power of two, at least 2.
REQ-007 clk  in  1  rising-edge clock for all state.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 auto_fill  in  1  1 selects continuous fill mode; 0 selects on-demand mode.
REQ-010 enable  in  1  permits generation in fill mode.
REQ-011 req  in  1  requests one word in on-demand mode (single-cycle pulse).
REQ-012 seed_load  in  1  loads seed_value into the LFSR.
REQ-013 seed_value  in  LFSR_WIDTH  new seed.
REQ-014 flush  in  1  empties the buffer.
REQ-015 out_data  out  OUT_WIDTH  head word, first-word-fall-through.
REQ-016 out_valid  out  1  buffer not empty.
REQ-017 out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
REQ-018 level  out  $clog2(FIFO_DEPTH)+1  number of stored words.
REQ-019 full, empty  out  1 each  buffer status.
REQ-020 req_dropped  out  1  one-cycle pulse when req arrives while full.
REQ-021 word_count  out  32  words generated since reset; wraps at 2^32.

Function
REQ-022 Each LFSR step SHALL output state[0], then set state to (state>>1), XORed with LFSR_POLY when state[0] was 1.
REQ-023 A generated word SHALL consist of OUT_WIDTH consecutive steps computed combinationally from the current state; the first step goes in bit 0; the state after the last step is registered.
REQ-024 The generate condition gen SHALL be !full && !seed_load && !flush && (auto_fill ? enable : req).
REQ-025 When gen is high, the word SHALL be written to the buffer on the same edge, and out_valid SHALL rise on the next cycle if the buffer was empty (latency 1).
REQ-026 Full SHALL block gen even when a pop occurs in the same cycle; pop and gen on one edge leave level unchanged.
REQ-027 req with full high and auto_fill low SHALL pulse req_dropped on the next cycle; state and word_count do not change.
REQ-028 In fill mode, req SHALL be ignored and req_dropped SHALL stay 0.
REQ-029 seed_load SHALL take priority over gen and load seed_value, or LFSR_SEED when seed_value is 0; buffer contents are kept.
REQ-030 flush SHALL empty the buffer on the next edge and have priority over push and pop; the LFSR state is kept.
REQ-031 Read and write pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; level = 0 means empty and level = FIFO_DEPTH means full.
REQ-032 out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-033 word_count SHALL increment by 1 on every gen.

Reset
REQ-034 On reset the block SHALL set: state = LFSR_SEED, pointers = 0, level = 0, empty = 1, full = 0, out_valid = 0, req_dropped = 0, word_count = 0, and out_data = 0.
REQ-035 Reset SHALL override all inputs in the same cycle, and an in-progress fill SHALL be discarded.

Structure
REQ-036 The shared package prng_pkg SHALL hold the default constants (width, seed, poly, out width, depth) and a step function that returns the next state and output bit.
REQ-037 The buffer SHALL be the one sub-module, fifo, parametrised on FIFO_WIDTH = OUT_WIDTH and FIFO_DEPTH, and extended with flush and level.
REQ-038 All outputs except out_data SHALL be registered; out_data comes directly from the buffer storage read.

Verification
REQ-039 With defaults, on-demand mode: req in cycles 1 and 3 -> out_data 4'h1 then 4'h7, state 8'h64, word_count 2.
REQ-040 Fill mode with enable = 1 and out_ready = 0 -> full after 16 cycles, level 16, word_count holds at 16; one pop -> exactly one refill.
REQ-041 Buffer full and on-demand mode: req -> one req_dropped pulse, level stays 16, word_count unchanged.
REQ-042 seed_load with seed_value 0 concurrent with req -> state 8'h01, no push; the next req yields 4'h1.
REQ-043 flush with pop and gen in the same cycle at level 5 -> level 0, out_valid 0, LFSR unchanged.
REQ-044 Reset asserted mid-fill at level 9 -> all REQ-034 values next cycle; the first word after reset is 4'h1.
